// File: rtl/radix4_booth_pp_accumulator.sv
// radix4_booth_pp_accumulator: accumulates radix-4 Booth partial-product rows into a signed 2*WIDTH product
module radix4_booth_pp_accumulator #(
    parameter int WIDTH  = 16,
    parameter int NUM_PP = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pp_valid,
    output logic                 pp_ready,
    input  logic [WIDTH:0]       pp_data,
    input  logic                 pp_s,
    input  logic                 pp_e,
    input  logic                 pp_last,
    output logic                 prod_valid,
    input  logic                 prod_ready,
    output logic [2*WIDTH-1:0]   prod_data,
    output logic [NUM_PP-1:0]    prod_neg_mask,
    output logic                 prod_err
);
    localparam int CW = NUM_PP > 1 ? $clog2(NUM_PP) : 1;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic accept, last_row, closing, row_err;
    logic [2*WIDTH-1:0] addend;
    if (NUM_PP != WIDTH / 2) begin : g_bad_num_pp
        $error("NUM_PP must equal WIDTH/2");
    end
    assign pp_ready = !rst && state != DONE;
    assign prod_valid = state == DONE;
    always_comb begin
        accept = pp_valid && pp_ready;
        last_row = cnt == CW'(NUM_PP - 1);
        closing = pp_last || last_row;
        row_err = (pp_last != last_row) || (pp_data != '0 && pp_e == pp_data[WIDTH]);
        addend = {{(WIDTH - 1){pp_data[WIDTH]}}, pp_data} << {cnt, 1'b0};
    end
    // cnt is 0 whenever state is IDLE, so row 0 always uses a zero shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            prod_data <= '0;
            prod_neg_mask <= '0;
            prod_err <= 1'b0;
        end else if (state == DONE) begin
            if (prod_ready) begin
                state <= IDLE;
                prod_err <= 1'b0;
            end
        end else if (accept) begin
            state <= closing ? DONE : ACCUM;
            cnt <= closing ? '0 : cnt + 1'b1;
            prod_data <= (state == IDLE) ? addend : prod_data + addend;
            prod_neg_mask <= ((state == IDLE) ? '0 : prod_neg_mask) | (NUM_PP'(pp_s) << cnt);
            prod_err <= ((state == IDLE) ? 1'b0 : prod_err) | row_err;
        end
    end
endmodule

// File: tb/tb_radix4_booth_pp_accumulator.sv
// tb_radix4_booth_pp_accumulator: directed-vector bench for the Booth row accumulator
module tb_radix4_booth_pp_accumulator;
    logic clk = 0, rst = 1;
    logic pp_valid = 0, pp_ready, pp_s = 0, pp_e = 0, pp_last = 0;
    logic [16:0] pp_data = '0;
    logic prod_valid, prod_ready = 0, prod_err;
    logic [31:0] prod_data;
    logic [7:0] prod_neg_mask;
    int checks = 0, failures = 0;
    logic [16:0] rv[8];
    logic [7:0] rs, re;

    radix4_booth_pp_accumulator #(.WIDTH(16), .NUM_PP(8)) dut (
        .clk(clk), .rst(rst), .pp_valid(pp_valid), .pp_ready(pp_ready),
        .pp_data(pp_data), .pp_s(pp_s), .pp_e(pp_e), .pp_last(pp_last),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
        .prod_neg_mask(prod_neg_mask), .prod_err(prod_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [16:0] d, input logic s, input logic e, input logic l, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        pp_valid = 1; pp_data = d; pp_s = s; pp_e = e; pp_last = l;
        @(posedge clk);
        #1 pp_valid = 0;
    endtask

    task automatic load(input logic [16:0] d0, input logic [16:0] d1, input logic [16:0] d6,
                        input logic [16:0] d7, input logic [7:0] s, input logic [7:0] e);
        rv = '{d0, d1, 17'h0, 17'h0, 17'h0, 17'h0, d6, d7};
        rs = s; re = e;
    endtask

    task automatic send_std(input int gap);
        for (int i = 0; i < 8; i++) begin
            send(rv[i], rs[i], re[i], i == 7, gap);
            if (i == 6) check("valid_before_last", prod_valid, 0);
        end
    endtask

    task automatic take(input string tag, input logic [31:0] d, input logic [7:0] m, input logic e);
        check({tag, "_valid"}, prod_valid, 1);
        check({tag, "_data"}, prod_data, d);
        check({tag, "_mask"}, prod_neg_mask, m);
        check({tag, "_err"}, prod_err, e);
        @(negedge clk) prod_ready = 1;
        @(posedge clk);
        #1 prod_ready = 0;
        check({tag, "_valid_drop"}, prod_valid, 0);
        check({tag, "_ready_idle"}, pp_ready, 1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_pp_ready", pp_ready, 0);
        check("rst_prod_valid", prod_valid, 0);
        check("rst_prod_data", prod_data, 0);
        check("rst_mask", prod_neg_mask, 0);
        check("rst_err", prod_err, 0);
        @(negedge clk) rst = 0;
        #1 check("idle_pp_ready", pp_ready, 1);

        load(17'h00003, 17'h00003, 17'h0, 17'h0, 8'h00, 8'h03);
        send_std(0);
        take("a3b5", 32'h0000000F, 8'h00, 0);

        load(17'h00002, 17'h1FFFF, 17'h0, 17'h0, 8'h01, 8'h01);
        send_std(0);
        take("am1b2", 32'hFFFFFFFE, 8'h01, 0);

        load(17'h0, 17'h0, 17'h00004, 17'h0FFFF, 8'h80, 8'hC0);
        send_std(3);
        @(negedge clk) begin pp_valid = 1; pp_data = 17'h00001; pp_last = 1; end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_data", prod_data, 32'h40000000);
            check("hold_valid", prod_valid, 1);
            check("hold_pp_ready", pp_ready, 0);
        end
        pp_valid = 0; pp_last = 0;
        take("big", 32'h40000000, 8'h80, 0);

        send(17'h00003, 0, 1, 0, 0);
        send(17'h00003, 0, 1, 0, 0);
        send(17'h0, 0, 0, 1, 0);
        take("early_last", 32'h0000000F, 8'h00, 1);
        load(17'h00003, 17'h00003, 17'h0, 17'h0, 8'h00, 8'h03);
        send_std(0);
        take("after_early", 32'h0000000F, 8'h00, 0);

        load(17'h00005, 17'h0, 17'h0, 17'h0, 8'h00, 8'h00);
        send_std(0);
        take("bad_head", 32'h00000005, 8'h00, 1);
        load(17'h0, 17'h0, 17'h0, 17'h0, 8'h00, 8'h00);
        send_std(0);
        take("zero_head", 32'h00000000, 8'h00, 0);

        load(17'h00003, 17'h00003, 17'h0, 17'h0, 8'h00, 8'h03);
        for (int i = 0; i < 5; i++) send(rv[i], rs[i], re[i], 0, 0);
        @(negedge clk) rst = 1;
        #1;
        check("abort_pp_ready", pp_ready, 0);
        check("abort_valid", prod_valid, 0);
        check("abort_data", prod_data, 0);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1 check("abort_no_valid", prod_valid, 0);
        send_std(0);
        take("post_abort", 32'h0000000F, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
